// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin core bus arbiter.
package core_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_PORTS  = 8;

  // One-hot to binary index; an all-zero input yields 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Requester-side and platform-master-side signals of the core bus arbiter.
interface core_bus_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
) ();
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]        req_start;
  logic [N_PORTS-1:0]        req_write;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_data_wr;
  logic [N_PORTS-1:0]        req_ready;
  logic [DATA_W-1:0]         req_data_rd;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;

  logic                      master_start;
  logic                      master_write;
  logic [ADDR_W-1:0]         master_addr;
  logic [DATA_W-1:0]         master_data_wr;
  logic                      master_ready;
  logic [DATA_W-1:0]         master_data_rd;

  modport slave (
    input  req_start, req_write, req_addr, req_data_wr, master_ready, master_data_rd,
    output req_ready, req_data_rd, busy, grant_id,
           master_start, master_write, master_addr, master_data_wr
  );

  modport master (
    output req_start, req_write, req_addr, req_data_wr, master_ready, master_data_rd,
    input  req_ready, req_data_rd, busy, grant_id,
           master_start, master_write, master_addr, master_data_wr
  );
endinterface

// File: rtl/core_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first pending port at or after rr_ptr, wrapping.
module core_bus_arbiter_rr_pick
  import core_bus_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   index
);

  logic [N_PORTS-1:0] sel;
  logic               found;
  int                 p;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      p = (int'(rr_ptr) + k) % N_PORTS;
      if (!found && pending[p]) begin
        sel[p] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any   = found;
  assign index = IDX_W'(onehot_to_idx(MAX_PORTS'(sel)));

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one platform master bus among N_PORTS requesters.
//   state | meaning
//   IDLE  | no transaction in flight; grant the next pending port, if any
//   WAIT  | master transaction issued for grant_id; waiting for master_ready
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  core_bus_arbiter_if.slave bus
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t             state, state_nxt;
  logic [N_PORTS-1:0] pending, pending_nxt, grant_mask;
  logic [IDX_W-1:0]   rr_ptr, grant_id, pick_idx, ptr_nxt;
  logic               pick_any, issue, complete;
  logic               master_start;
  logic [N_PORTS-1:0] req_ready;
  logic [DATA_W-1:0]  req_data_rd;

  core_bus_arbiter_rr_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .any     (pick_any),
    .index   (pick_idx)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = WAIT;
      WAIT:    if (bus.master_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue    = (state == IDLE) && pick_any;
    complete = (state == WAIT) && bus.master_ready;
  end

  assign grant_mask  = {{(N_PORTS-1){1'b0}}, 1'b1} << grant_id;
  // A start on an already-pending port is absorbed by the OR; no second transaction.
  assign pending_nxt = (pending | bus.req_start) & ~(complete ? grant_mask : '0);
  assign ptr_nxt     = (grant_id == IDX_W'(N_PORTS-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pending      <= '0;
      rr_ptr       <= '0;
      grant_id     <= '0;
      master_start <= 1'b0;
      req_ready    <= '0;
      req_data_rd  <= '0;
    end else begin
      pending      <= pending_nxt;
      master_start <= issue;
      req_ready    <= complete ? grant_mask : '0;
      if (issue) grant_id <= pick_idx;
      if (complete) begin
        req_data_rd <= bus.master_data_rd;
        rr_ptr      <= ptr_nxt;
      end
    end
  end

  always_comb begin
    bus.master_write   = 1'b0;
    bus.master_addr    = '0;
    bus.master_data_wr = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_id == IDX_W'(i)) begin
        bus.master_write   = bus.req_write[i];
        bus.master_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
        bus.master_data_wr = bus.req_data_wr[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.master_start = master_start;
  assign bus.req_ready    = req_ready;
  assign bus.req_data_rd  = req_data_rd;
  assign bus.busy         = (state != IDLE);
  assign bus.grant_id     = grant_id;

endmodule
